// File: rtl/pipelined_addsub_pkg.sv
// Shared configuration helpers for the pipelined add/subtract unit:
// slice width derivation and the legality check for WIDTH/STAGES.
package pipelined_addsub_pkg;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One carry-chain segment: W-bit add with registered sum and carry-out,
// advancing only when en_i is high.
module addsub_slice #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] add_d;
  logic [W-1:0] sum_q;
  logic cout_q;

  assign add_d = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, c_i};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (en_i) begin
      sum_q  <= add_d[W-1:0];
      cout_q <= add_d[W];
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract with valid/ready on both sides; the carry
// chain is split into STAGES slices with operand skew and result deskew.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CHUNK  = chunk_w(WIDTH, STAGES);
  localparam bit CFG_OK = cfg_ok(WIDTH, STAGES);

  generate
    if (!CFG_OK) begin : g_bad_cfg
      $error("pipelined_addsub: WIDTH must be a positive multiple of STAGES");
    end
  endgenerate

  logic                               adv;
  logic [STAGES:0]                    vld_pipe;
  logic [WIDTH-1:0]                   b_eff;
  logic                               cin_eff;
  // Per stage: full-width operand copies (skew) and lower result slices (deskew)
  logic [STAGES-1:0][WIDTH-1:0]       opa_q, opb_q, res_q, word;
  logic [STAGES-1:0][CHUNK-1:0]       sl_a, sl_b, sl_s;
  logic [STAGES-1:0]                  sl_c, sl_co;

  assign out_valid   = vld_pipe[STAGES];
  assign adv         = !out_valid || out_ready;
  assign in_ready    = adv && !rst;
  assign vld_pipe[0] = in_valid && in_ready;

  assign b_eff   = in_sub ? ~in_b : in_b;
  assign cin_eff = in_sub | in_cin;

  always_comb begin
    sl_a    = '0;
    sl_b    = '0;
    sl_c    = '0;
    word    = res_q;
    sl_a[0] = in_a[0 +: CHUNK];
    sl_b[0] = b_eff[0 +: CHUNK];
    sl_c[0] = cin_eff;
    word[0][0 +: CHUNK] = sl_s[0];
    for (int k = 1; k < STAGES; k++) begin
      sl_a[k] = opa_q[k-1][k*CHUNK +: CHUNK];
      sl_b[k] = opb_q[k-1][k*CHUNK +: CHUNK];
      sl_c[k] = sl_co[k-1];
      word[k][k*CHUNK +: CHUNK] = sl_s[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe[STAGES:1] <= '0;
      opa_q              <= '0;
      opb_q              <= '0;
      res_q              <= '0;
    end else if (adv) begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      opa_q[0]           <= in_a;
      opb_q[0]           <= b_eff;
      res_q[0]           <= '0;
      for (int k = 1; k < STAGES; k++) begin
        opa_q[k] <= opa_q[k-1];
        opb_q[k] <= opb_q[k-1];
        res_q[k] <= word[k-1];
      end
    end
  end

  generate
    for (genvar g = 0; g < STAGES; g++) begin : g_slice
      addsub_slice #(.W(CHUNK)) u_slice (
        .clk    (clk),
        .rst    (rst),
        .en_i   (adv),
        .a_i    (sl_a[g]),
        .b_i    (sl_b[g]),
        .c_i    (sl_c[g]),
        .sum_o  (sl_s[g]),
        .cout_o (sl_co[g])
      );
    end
  endgenerate

  // Overflow uses the original A and effective B MSBs that travelled with the beat
  assign out_sum  = word[STAGES-1];
  assign out_cout = sl_co[STAGES-1];
  assign out_ovf  = (opa_q[STAGES-1][WIDTH-1] == opb_q[STAGES-1][WIDTH-1]) &&
                    (out_sum[WIDTH-1] != opa_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: three configurations (16/4, 5/5, 8/1),
// vector table plus stall, back-to-back and reset sequences.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  iv, icin, isub, ordy, ir, ov, oc, oo;
  logic [15:0] ia [3];
  logic [15:0] ib [3];
  logic [15:0] os [3];
  logic [15:0] s0;
  logic [4:0]  s1;
  logic [7:0]  s2;

  assign os[0] = s0;
  assign os[1] = {11'b0, s1};
  assign os[2] = {8'b0, s2};

  pipelined_addsub #(.WIDTH(16), .STAGES(4)) d0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0]), .in_b(ib[0]),
    .in_cin(icin[0]), .in_sub(isub[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_sum(s0), .out_cout(oc[0]), .out_ovf(oo[0]));

  pipelined_addsub #(.WIDTH(5), .STAGES(5)) d1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1][4:0]), .in_b(ib[1][4:0]),
    .in_cin(icin[1]), .in_sub(isub[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_sum(s1), .out_cout(oc[1]), .out_ovf(oo[1]));

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) d2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(ia[2][7:0]), .in_b(ib[2][7:0]),
    .in_cin(icin[2]), .in_sub(isub[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_sum(s2), .out_cout(oc[2]), .out_ovf(oo[2]));

  typedef struct {
    int          dut;
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] sum;
    logic        cout, ovf;
    int          lat;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference for the 16-bit unit: {ovf, cout, sum}
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
    logic [15:0] bb;
    logic [16:0] r;
    logic        v;
    bb = sub ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + {16'b0, (sub ? 1'b1 : cin)};
    v  = (a[15] == bb[15]) && (r[15] != a[15]);
    return {v, r};
  endfunction

  task automatic drive(input int d, input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    iv[d] = v; ia[d] = a; ib[d] = b; icin[d] = cin; isub[d] = sub;
  endtask

  task automatic run_vec(input vec_t t, input string nm);
    int n;
    @(negedge clk);
    drive(t.dut, 1'b1, t.a, t.b, t.cin, t.sub);
    #1 chk({nm, ".in_ready"}, {31'b0, ir[t.dut]}, 32'd1);
    @(negedge clk);
    iv[t.dut] = 1'b0;
    n = 1;
    while (!ov[t.dut] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ".latency"}, n, t.lat);
    chk({nm, ".sum"}, {16'b0, os[t.dut]}, {16'b0, t.sum});
    chk({nm, ".cout"}, {31'b0, oc[t.dut]}, {31'b0, t.cout});
    chk({nm, ".ovf"}, {31'b0, oo[t.dut]}, {31'b0, t.ovf});
  endtask

  vec_t tbl [14];

  logic [15:0] ra [8];
  logic [15:0] rb [8];
  logic        rc [8];
  logic        rs [8];
  logic [17:0] exq [8];

  initial begin
    int sent, got, stall, n, extra;
    logic [17:0] held;

    tbl[0]  = '{0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 4};
    tbl[1]  = '{0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4};
    tbl[2]  = '{0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4};
    tbl[3]  = '{0, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4};
    tbl[4]  = '{0, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4};
    tbl[5]  = '{0, 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 4};
    tbl[6]  = '{0, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4};
    tbl[7]  = '{0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4};
    tbl[8]  = '{0, 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 4};
    tbl[9]  = '{0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4};
    tbl[10] = '{1, 16'h001F, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 5};
    tbl[11] = '{1, 16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b1, 5};
    tbl[12] = '{2, 16'h0080, 16'h0080, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1};
    tbl[13] = '{2, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'h00FE, 1'b0, 1'b0, 1};

    for (int d = 0; d < 3; d++) begin
      drive(d, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      ordy[d] = 1'b1;
    end

    // Reset state
    #12;
    chk("rst.out_valid", {29'b0, ov}, 32'd0);
    chk("rst.in_ready", {29'b0, ir}, 32'd0);
    chk("rst.sum0", {16'b0, os[0]}, 32'd0);
    chk("rst.cout_ovf", {26'b0, oc, oo}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel.in_ready", {29'b0, ir}, 32'd7);

    for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back beats must emerge on consecutive cycles
    @(negedge clk);
    drive(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b.first", {13'b0, ov[0], oc[0], oo[0], os[0]}, {13'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
    @(negedge clk);
    chk("b2b.second", {13'b0, ov[0], oc[0], oo[0], os[0]}, {13'b0, 1'b1, 1'b0, 1'b1, 16'h8000});
    @(negedge clk);

    // Back-pressure: 8 beats, consumer stalls 5 cycles from the first result
    for (int i = 0; i < 8; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rc[i] = 1'($urandom);
      rs[i] = 1'($urandom);
      exq[i] = model16(ra[i], rb[i], rc[i], rs[i]);
    end
    ordy[0] = 1'b0;
    sent = 0; got = 0; stall = 0; held = '0;
    drive(0, 1'b1, ra[0], rb[0], rc[0], rs[0]);
    #1;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      if (ov[0]) begin
        if (ordy[0]) begin
          chk($sformatf("stall.res%0d", got), {14'b0, oo[0], oc[0], os[0]}, {14'b0, exq[got]});
          got++;
        end else begin
          stall++;
          chk("stall.in_ready", {31'b0, ir[0]}, 32'd0);
          if (stall == 1) held = {oo[0], oc[0], os[0]};
          else chk("stall.hold", {14'b0, oo[0], oc[0], os[0]}, {14'b0, held});
        end
      end
      if (iv[0] && ir[0]) sent++;
      @(posedge clk);
      @(negedge clk);
      if (sent < 8) drive(0, 1'b1, ra[sent], rb[sent], rc[sent], rs[sent]);
      else iv[0] = 1'b0;
      if (stall >= 5) ordy[0] = 1'b1;
      #1;
    end
    chk("stall.got", got, 8);
    chk("stall.sent", sent, 8);
    chk("stall.cycles", stall, 5);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ov[0]) extra++;
    end
    chk("stall.no_dup", extra, 0);

    // Reset mid-flight discards in-flight beats
    @(negedge clk);
    drive(0, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 16'h3333, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 16'h4444, 16'h0004, 1'b0, 1'b1);
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    chk("mid.valid_before", {31'b0, ov[0]}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid.valid_rst", {31'b0, ov[0]}, 32'd0);
    chk("mid.sum_rst", {16'b0, os[0]}, 32'd0);
    chk("mid.in_ready_rst", {31'b0, ir[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mid.in_ready_rel", {31'b0, ir[0]}, 32'd1);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov[0]) extra++;
    end
    chk("mid.no_stale", extra, 0);
    run_vec('{0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 4}, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
